// File: rtl/nb_pkg.sv
// Shared types and constants for the Naive Bayes scoring stage.
// Holds the Q0.8 width, FSM state enum, lane record and priors.
package nb_pkg;

    localparam int Q_W       = 8;
    localparam int EXP_MAX_W = 16;

    localparam logic [Q_W-1:0] PRIOR_DEF = 8'h80;

    typedef enum logic [1:0] {
        ACC,
        MUL,
        DECIDE,
        DONE
    } state_t;

    // Exponent field is sized for the widest supported EXP_W.
    // Lanes zero-extend their narrower exponent into it.
    typedef struct packed {
        logic [Q_W-1:0]       m;
        logic [EXP_MAX_W-1:0] e;
        logic                 sat;
    } lane_t;

    // Leading zeros of a product known to be >= 0x0080 (0..8).
    function automatic logic [3:0] nb_lz(
        input logic [2*Q_W-1:0] p
    );
        logic [3:0] n;
        logic       f;
        n = 4'd8;
        f = 1'b0;
        for (int i = 2*Q_W-1; i >= Q_W; i--) begin
            if (!f && p[i]) begin
                n = 4'(2*Q_W-1-i);
                f = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/nb_lane.sv
// One class lane: mantissa/exponent score with 8x8 array multiply.
// Ports: clk, rst, load (reload prior), step (apply p), p, st (record).
module nb_mul8 #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod
);

    logic [2*W-1:0] acc;

    // Shift-and-add array of partial products.
    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                acc = acc + ((2*W)'(a) << i);
            end
        end
    end

    assign prod = acc;

endmodule

module nb_lane
    import nb_pkg::*;
#(
    parameter logic [Q_W-1:0] PRIOR = PRIOR_DEF,
    parameter int             EXP_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [Q_W-1:0] p,
    output lane_t          st
);

    logic [Q_W-1:0]   m;
    logic [EXP_W-1:0] e;
    logic             sat;

    logic [2*Q_W-1:0] prod;
    logic [3:0]       lz;
    logic [EXP_W:0]   sum;
    logic             ovf;

    nb_mul8 #(
        .W (Q_W)
    ) u_mul (
        .a    (m),
        .b    (p),
        .prod (prod)
    );

    assign lz  = nb_lz(prod);
    assign sum = {1'b0, e} + (EXP_W+1)'(lz);
    assign ovf = sum[EXP_W];

    always_ff @(posedge clk) begin
        if (rst || load) begin
            m   <= PRIOR;
            e   <= '0;
            sat <= 1'b0;
        end else if (step) begin
            // Normalize so m[7]=1; low product bits are dropped.
            m   <= Q_W'((prod << lz) >> Q_W);
            e   <= ovf ? '1 : sum[EXP_W-1:0];
            sat <= sat | ovf;
        end
    end

    assign st = '{m: m, e: EXP_MAX_W'(e), sat: sat};

endmodule

// File: rtl/nb_score_accumulator.sv
// Naive Bayes ham/spam scorer: per-word products, decision on last.
// Ports: clk, rst, in_* pair handshake, out_* decision handshake.
// NB_WORD_COUNT_EN adds out_words (pairs accepted this message).
module nb_score_accumulator
    import nb_pkg::*;
#(
    parameter logic [7:0] PRIOR_SPAM = PRIOR_DEF,
    parameter logic [7:0] PRIOR_HAM  = PRIOR_DEF,
    parameter int         EXP_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [Q_W-1:0]    p_spam,
    input  logic [Q_W-1:0]    p_ham,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              is_spam,
    output logic [EXP_W:0]    out_exp_diff,
    output logic              out_sat
`ifdef NB_WORD_COUNT_EN
    ,
    output logic [15:0]       out_words
`endif
);

    state_t state;
    state_t state_n;

    logic [Q_W-1:0] ps_q;
    logic [Q_W-1:0] ph_q;
    logic           last_q;

    logic accept;
    logic step;
    logic decide;
    logic reload;

    lane_t ls;
    lane_t lh;

    logic           spam_win;
    logic [EXP_W:0] diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        decide  = 1'b0;
        reload  = 1'b0;
        unique case (state)
            ACC: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                step    = 1'b1;
                state_n = last_q ? DECIDE : ACC;
            end
            DECIDE: begin
                decide  = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    reload  = 1'b1;
                    state_n = ACC;
                end
            end
            default: state_n = ACC;
        endcase
    end

    assign in_ready = (state == ACC) && !rst;

    // Zero likelihoods are clamped so a lane never collapses to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q   <= 8'h01;
            ph_q   <= 8'h01;
            last_q <= 1'b0;
        end else if (accept) begin
            ps_q   <= (p_spam == '0) ? 8'h01 : p_spam;
            ph_q   <= (p_ham == '0) ? 8'h01 : p_ham;
            last_q <= in_last;
        end
    end

    nb_lane #(
        .PRIOR (PRIOR_SPAM),
        .EXP_W (EXP_W)
    ) u_spam (
        .clk  (clk),
        .rst  (rst),
        .load (reload),
        .step (step),
        .p    (ps_q),
        .st   (ls)
    );

    nb_lane #(
        .PRIOR (PRIOR_HAM),
        .EXP_W (EXP_W)
    ) u_ham (
        .clk  (clk),
        .rst  (rst),
        .load (reload),
        .step (step),
        .p    (ph_q),
        .st   (lh)
    );

    // Larger exponent means smaller score; ties go to ham.
    assign spam_win = (ls.e < lh.e) ||
                      ((ls.e == lh.e) && (ls.m > lh.m));

    assign diff = (EXP_W+1)'(lh.e) - (EXP_W+1)'(ls.e);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            is_spam      <= 1'b0;
            out_exp_diff <= '0;
            out_sat      <= 1'b0;
        end else if (decide) begin
            out_valid    <= 1'b1;
            is_spam      <= spam_win;
            out_exp_diff <= diff;
            out_sat      <= ls.sat | lh.sat;
        end else if (reload) begin
            out_valid    <= 1'b0;
        end
    end

`ifdef NB_WORD_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            out_words <= '0;
        end else if (accept && (out_words != 16'hFFFF)) begin
            out_words <= out_words + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nb_score_accumulator.sv
// Bench for nb_score_accumulator: directed cases plus random messages.
// Expected scores come from an arithmetic model of the scoring rules.
module tb_nb_score_accumulator;

    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [7:0]    p_spam;
    logic [7:0]    p_ham;
    logic          out_valid;
    logic          out_ready;
    logic          is_spam;
    logic [EW:0]   out_exp_diff;
    logic          out_sat;
`ifdef NB_WORD_COUNT_EN
    logic [15:0]   out_words;
`endif

    nb_score_accumulator #(
        .PRIOR_SPAM (8'h80),
        .PRIOR_HAM  (8'h80),
        .EXP_W      (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .p_spam       (p_spam),
        .p_ham        (p_ham),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .is_spam      (is_spam),
        .out_exp_diff (out_exp_diff),
        .out_sat      (out_sat)
`ifdef NB_WORD_COUNT_EN
        ,
        .out_words    (out_words)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int ms, es, mh, eh, nwords;
    bit msat;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = 128; es = 0; mh = 128; eh = 0;
        msat = 1'b0; nwords = 0;
    endtask

    // Score = m/256 * 2^-e; renormalize by doubling until m >= 128.
    task automatic model_lane(inout int m, inout int e,
                              inout bit s, input int p);
        int pp, prod, lz;
        pp   = (p == 0) ? 1 : p;
        prod = m * pp;
        lz   = 0;
        while (prod < 32768) begin
            prod = prod * 2;
            lz++;
        end
        m = prod / 256;
        e = e + lz;
        if (e > EMAX) begin
            e = EMAX;
            s = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] ps, input logic [7:0] ph,
                        input bit last);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        in_last  = last;
        p_spam   = ps;
        p_ham    = ph;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_lane(ms, es, msat, int'(ps));
        model_lane(mh, eh, msat, int'(ph));
        nwords++;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_wait", {31'b0, out_valid}, 1);
    endtask

    task automatic check_lanes(input string tag);
        chk({tag, "_ms"}, 32'(dut.ls.m), ms);
        chk({tag, "_es"}, 32'(dut.ls.e), es);
        chk({tag, "_mh"}, 32'(dut.lh.m), mh);
        chk({tag, "_eh"}, 32'(dut.lh.e), eh);
    endtask

    task automatic check_result(input string tag);
        bit sw;
        sw = (es < eh) || ((es == eh) && (ms > mh));
        chk({tag, "_spam"}, {31'b0, is_spam}, 32'(sw));
        chk({tag, "_diff"}, 32'(out_exp_diff), (eh - es) & 31);
        chk({tag, "_sat"}, {31'b0, out_sat}, 32'(msat));
        chk({tag, "_rdy"}, {31'b0, in_ready}, 0);
`ifdef NB_WORD_COUNT_EN
        chk({tag, "_words"}, 32'(out_words), nwords);
`endif
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("take_clear", {31'b0, out_valid}, 0);
        model_reset();
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r < 3) return 8'($urandom_range(1, 255));
        return 8'($urandom_range(128, 255));
    endfunction

    initial begin
        logic       hs;
        logic [4:0] hd;
        int         len;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        p_spam    = 8'h00;
        p_ham     = 8'h00;
        out_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_spam", {31'b0, is_spam}, 0);
        chk("rst_diff", 32'(out_exp_diff), 0);
        chk("rst_sat", {31'b0, out_sat}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, in_ready}, 1);
        check_lanes("rst");

        // in_last alone must do nothing.
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        @(posedge clk); #1;
        chk("lastonly_ready", {31'b0, in_ready}, 1);
        chk("lastonly_valid", {31'b0, out_valid}, 0);

        // Equal likelihoods: both lanes 0x80, e=1, ham wins tie.
        send(8'h80, 8'h80, 1'b1);
        chk("s1_lat0", {31'b0, out_valid}, 0);
        @(posedge clk); #1;
        chk("s1_lat1", {31'b0, out_valid}, 0);
        check_lanes("s1");
        chk("s1_m_const", 32'(dut.ls.m), 32'h80);
        chk("s1_e_const", 32'(dut.ls.e), 1);
        @(posedge clk); #1;
        chk("s1_lat2", {31'b0, out_valid}, 1);
        check_result("s1");
        chk("s1_spam_const", {31'b0, is_spam}, 0);
        take();

        send(8'hFF, 8'h01, 1'b1);
        wait_out();
        check_lanes("s2");
        chk("s2_ms_const", 32'(dut.ls.m), 32'hFF);
        chk("s2_eh_const", 32'(dut.lh.e), 8);
        check_result("s2");
        chk("s2_diff_const", 32'(out_exp_diff), 7);
        take();

        send(8'h80, 8'h00, 1'b1);
        wait_out();
        check_result("s3");
        chk("s3_eh_const", 32'(dut.lh.e), 8);
        chk("s3_spam_const", {31'b0, is_spam}, 1);
        take();

        send(8'h01, 8'h01, 1'b0);
        @(posedge clk); #1;
        chk("s4_e8", 32'(dut.ls.e), 8);
        send(8'h01, 8'h01, 1'b1);
        wait_out();
        check_lanes("s4");
        chk("s4_e15", 32'(dut.ls.e), 15);
        chk("s4_sat_const", {31'b0, out_sat}, 1);
        check_result("s4");
        take();

        // Decision held while downstream stalls.
        send(8'hC3, 8'h91, 1'b1);
        wait_out();
        check_result("s5");
        hs = is_spam;
        hd = out_exp_diff;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("s5_hold_valid", {31'b0, out_valid}, 1);
            chk("s5_hold_ready", {31'b0, in_ready}, 0);
            chk("s5_hold_spam", {31'b0, is_spam}, {31'b0, hs});
            chk("s5_hold_diff", 32'(out_exp_diff), 32'(hd));
        end
        take();
        send(8'h80, 8'h80, 1'b1);
        wait_out();
        chk("s5_reload_m", 32'(dut.ls.m), 32'h80);
        chk("s5_reload_e", 32'(dut.lh.e), 1);
        check_result("s5b");
        take();

        // Reset one cycle after a non-last pair.
        send(8'h90, 8'hA0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_lanes("s6");
        chk("s6_valid", {31'b0, out_valid}, 0);
        chk("s6_ready", {31'b0, in_ready}, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("s6_quiet", {31'b0, out_valid}, 0);
        end

        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                send(pick(), pick(), i == len - 1);
            end
            wait_out();
            check_lanes("rnd");
            check_result("rnd");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            take();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
